// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word stream from the on-chip data source into the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small input FIFO and back-to-back framing.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                        uart_clock,
    input  logic                        uart_reset,
    uart_tx_fifo_if.slave               tx_if,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic                        two_stop,
    input  logic                        parity_odd,
    output logic                        uart_d_out,
    output logic                        uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic                 two_stop_q, two_stop_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 d_out_q, d_out_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                 push, pop, tick, last_stop;

`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`else
    logic                 unused_parity;
    assign unused_parity = parity_odd;
`endif

    // Next-state, FIFO bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        two_stop_d = two_stop_q;
        bit_d      = bit_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        pop        = 1'b0;
        push       = tx_if.tx_valid & ready_q;
        tick       = (baud_cnt_q == div_q);
        baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_WIDTH'(1);
        last_stop  = !two_stop_q || (bit_q != '0);

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                pop        = (count_q != '0);
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_d   = '0;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        // Chain straight into the next frame when a word is waiting.
                        pop     = (count_q != '0);
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: load head word and freeze the per-frame settings.
        if (pop) begin
            state_d    = ST_START;
            shift_d    = mem_q[rd_ptr_q];
            div_d      = baud_div;
            two_stop_d = two_stop;
            bit_d      = '0;
            baud_cnt_d = '0;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
            par_d      = ^mem_q[rd_ptr_q] ^ parity_odd;
`endif
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d  = (state_d != ST_IDLE) || (count_d != '0);

        case (state_d)
            ST_START:  d_out_d = 1'b0;
            ST_DATA:   d_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: d_out_d = par_d;
`endif
            default:   d_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            two_stop_q <= 1'b0;
            bit_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            d_out_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            two_stop_q <= two_stop_d;
            bit_q      <= bit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            d_out_q    <= d_out_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge uart_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_if.tx_data;
        end
    end

    assign tx_if.tx_ready = ready_q;
    assign uart_d_out     = d_out_q;
    assign uart_tx_busy   = busy_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized traffic
// compared against a frame-level reference model.
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        uart_reset;
    logic [15:0] baud_div;
    logic        two_stop;
    logic        parity_odd;
    logic        uart_d_out;
    logic        uart_tx_busy;
    logic [2:0]  fifo_count;
    int          n_checks = 0;
    int          n_errors = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) tx_if ();

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .uart_clock   (clk),
        .uart_reset   (uart_reset),
        .tx_if        (tx_if),
        .baud_div     (baud_div),
        .two_stop     (two_stop),
        .parity_odd   (parity_odd),
        .uart_d_out   (uart_d_out),
        .uart_tx_busy (uart_tx_busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference frame: start, data LSB first, optional parity, stop bit(s); unused bits 1.
    function automatic void build_frame(input logic [7:0] w, input logic two, input logic odd,
                                        output logic [15:0] bits, output int n);
        bits = '1;
        n = 0;
        bits[4'(n)] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[4'(n)] = w[3'(i)]; n++;
        end
        if (PAR_EN) begin
            bits[4'(n)] = (^w) ^ odd; n++;
        end
        bits[4'(n)] = 1'b1; n++;
        if (two) begin
            bits[4'(n)] = 1'b1; n++;
        end
    endfunction

    // Waits for a start bit then records one value per bit period, flagging any in-bit change.
    task automatic capture_frame(input int div, input int nbits, output logic [15:0] bits,
                                 output int waits, output bit glitch, output bit timeout);
        logic v;
        bits = '1; waits = 0; glitch = 1'b0; timeout = 1'b0;
        do begin
            @(negedge clk);
            waits++;
        end while (uart_d_out !== 1'b0 && waits < 1000);
        if (uart_d_out !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= div; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                v = uart_d_out;
                if (c == 0) bits[4'(b)] = v;
                else if (v !== bits[4'(b)]) glitch = 1'b1;
            end
        end
    endtask

    task automatic push_one(input logic [7:0] d, output bit acc);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        acc = tx_if.tx_ready;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        uart_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        uart_reset = 1'b1;
        @(negedge clk);
        n_checks++; if (uart_d_out !== 1'b1)   begin n_errors++; $display("FAIL reset_d_out: got %b expected 1", uart_d_out); end
        n_checks++; if (tx_if.tx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", tx_if.tx_ready); end
        n_checks++; if (fifo_count !== 3'd0)   begin n_errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", uart_tx_busy); end
    endtask

    task automatic test_single;
        logic [15:0] exp, got;
        int n, waits;
        bit acc, gl, to;
        baud_div = 16'd3; two_stop = 1'b0; parity_odd = 1'b0;
        build_frame(8'hA5, 1'b0, 1'b0, exp, n);
        push_one(8'hA5, acc);
        n_checks++; if (acc !== 1'b1) begin n_errors++; $display("FAIL single_accept: got %b expected 1", acc); end
        capture_frame(3, n, got, waits, gl, to);
        n_checks++; if (to !== 1'b0)  begin n_errors++; $display("FAIL single_timeout: got %b expected 0", to); end
        n_checks++; if (waits != 1)   begin n_errors++; $display("FAIL single_latency: got %0d expected 1", waits); end
        n_checks++; if (got !== exp)  begin n_errors++; $display("FAIL single_bits: got %b expected %b", got, exp); end
        n_checks++; if (gl !== 1'b0)  begin n_errors++; $display("FAIL single_bit_period: got glitch %b expected 0", gl); end
        n_checks++; if (uart_tx_busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_last: got %b expected 1", uart_tx_busy); end
        @(negedge clk);
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end: got %b expected 0", uart_tx_busy); end
        n_checks++; if (uart_d_out !== 1'b1)   begin n_errors++; $display("FAIL single_idle_line: got %b expected 1", uart_d_out); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [6];
        int L;
        words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        L = 10 + int'(PAR_EN);
        baud_div = 16'd0; two_stop = 1'b0; parity_odd = 1'b0;
        fork
            begin
                int idx, mcount;
                bit acc, popm;
                idx = 0; mcount = 0;
                for (int t = 1; t <= L * 6 + 8; t++) begin
                    if (idx < 6) begin tx_if.tx_valid = 1'b1; tx_if.tx_data = words[idx]; end
                    else tx_if.tx_valid = 1'b0;
                    acc  = (idx < 6) && (mcount != DEPTH);
                    popm = (t >= 2) && (((t - 2) % L) == 0) && (mcount > 0);
                    @(negedge clk);
                    mcount = mcount + int'(acc) - int'(popm);
                    if (acc) idx++;
                    n_checks++; if (int'(fifo_count) != mcount) begin n_errors++; $display("FAIL b2b_count t=%0d: got %0d expected %0d", t, fifo_count, mcount); end
                    n_checks++; if (tx_if.tx_ready !== (mcount != DEPTH)) begin n_errors++; $display("FAIL b2b_ready t=%0d: got %b expected %b", t, tx_if.tx_ready, mcount != DEPTH); end
                end
                tx_if.tx_valid = 1'b0;
            end
            begin
                logic [15:0] exp, got;
                int n, waits;
                bit gl, to;
                for (int k = 0; k < 6; k++) begin
                    build_frame(words[k], 1'b0, 1'b0, exp, n);
                    capture_frame(0, n, got, waits, gl, to);
                    n_checks++; if (to !== 1'b0 || gl !== 1'b0) begin n_errors++; $display("FAIL b2b_frame%0d_shape: got timeout %b glitch %b expected 0 0", k, to, gl); end
                    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL b2b_frame%0d_bits: got %b expected %b", k, got, exp); end
                    n_checks++; if (waits != ((k == 0) ? 2 : 1)) begin n_errors++; $display("FAIL b2b_frame%0d_gap: got %0d expected %0d", k, waits, (k == 0) ? 2 : 1); end
                end
            end
        join
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_end: got %b expected 0", uart_tx_busy); end
    endtask

    task automatic test_two_stop;
        logic [15:0] exp, got;
        int n, waits;
        bit acc, gl, to;
        baud_div = 16'd0; two_stop = 1'b1; parity_odd = 1'b0;
        build_frame(8'hFF, 1'b1, 1'b0, exp, n);
        push_one(8'hFF, acc);
        fork
            capture_frame(0, n, got, waits, gl, to);
            begin
                repeat (3) @(negedge clk);
                two_stop = 1'b0;
                baud_div = 16'd5;
            end
        join
        n_checks++; if (acc !== 1'b1 || to !== 1'b0) begin n_errors++; $display("FAIL two_stop_start: got accept %b timeout %b expected 1 0", acc, to); end
        n_checks++; if (got !== exp || gl !== 1'b0) begin n_errors++; $display("FAIL two_stop_bits: got %b glitch %b expected %b glitch 0", got, gl, exp); end
        n_checks++; if (uart_tx_busy !== 1'b1) begin n_errors++; $display("FAIL two_stop_second_stop: got busy %b expected 1", uart_tx_busy); end
        @(negedge clk);
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_errors++; $display("FAIL two_stop_end: got busy %b expected 0", uart_tx_busy); end
        baud_div = 16'd0; two_stop = 1'b0;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0]  w [2];
        logic [15:0] exp, got;
        int n, waits;
        bit acc, gl, to;
        w = '{8'h07, 8'h03};
        baud_div = 16'd1; two_stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            parity_odd = (k == 1);
            build_frame(w[k], 1'b0, parity_odd, exp, n);
            push_one(w[k], acc);
            capture_frame(1, n, got, waits, gl, to);
            n_checks++; if (n != 11) begin n_errors++; $display("FAIL parity_len%0d: got %0d expected 11", k, n); end
            n_checks++; if (got[9] !== 1'b1) begin n_errors++; $display("FAIL parity_bit%0d: got %b expected 1", k, got[9]); end
            n_checks++; if (got !== exp || gl || to) begin n_errors++; $display("FAIL parity_frame%0d: got %b expected %b", k, got, exp); end
            @(negedge clk);
            n_checks++; if (uart_tx_busy !== 1'b0) begin n_errors++; $display("FAIL parity_end%0d: got busy %b expected 0", k, uart_tx_busy); end
        end
        parity_odd = 1'b0;
    endtask
`endif

    task automatic test_random;
        logic [7:0] sb [$];
        int div, nwords;
        logic two, odd;
        div = int'($urandom_range(0, 3));
        two = 1'($urandom_range(0, 1));
        odd = 1'($urandom_range(0, 1));
        nwords = 10;
        baud_div = 16'(div); two_stop = two; parity_odd = odd;
        fork
            begin
                int sent;
                logic rdy, v;
                logic [7:0] d;
                sent = 0;
                while (sent < nwords) begin
                    if ($urandom_range(0, 3) == 0) tx_if.tx_valid = 1'b0;
                    else begin tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'($urandom); end
                    rdy = tx_if.tx_ready; v = tx_if.tx_valid; d = tx_if.tx_data;
                    @(negedge clk);
                    if (v && rdy) begin sb.push_back(d); sent++; end
                    n_checks++; if (fifo_count > 3'(DEPTH)) begin n_errors++; $display("FAIL rand_count_max: got %0d expected <= %0d", fifo_count, DEPTH); end
                    n_checks++; if (tx_if.tx_ready !== (fifo_count != 3'(DEPTH))) begin n_errors++; $display("FAIL rand_ready: got %b expected %b", tx_if.tx_ready, fifo_count != 3'(DEPTH)); end
                end
                tx_if.tx_valid = 1'b0;
            end
            begin
                logic [15:0] exp, got;
                int n, waits;
                bit gl, to;
                for (int k = 0; k < nwords; k++) begin
                    capture_frame(div, 1 + 8 + int'(PAR_EN) + 1 + int'(two), got, waits, gl, to);
                    if (sb.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL rand_unexpected_frame%0d: got frame %b expected none", k, got);
                    end else begin
                        build_frame(sb.pop_front(), two, odd, exp, n);
                        n_checks++; if (got !== exp || gl || to) begin n_errors++; $display("FAIL rand_frame%0d div=%0d two=%b: got %b expected %b", k, div, two, got, exp); end
                    end
                end
            end
        join
        @(negedge clk);
        n_checks++; if (uart_tx_busy !== 1'b0 || fifo_count !== 3'd0) begin n_errors++; $display("FAIL rand_drain: got busy %b count %0d expected 0 0", uart_tx_busy, fifo_count); end
        baud_div = 16'd0; two_stop = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] words [3];
        int bad;
        words = '{8'h08, 8'hC3, 8'h7E};
        baud_div = 16'd7; two_stop = 1'b0; parity_odd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_if.tx_valid = 1'b1;
            tx_if.tx_data  = words[i];
            if (i == 2) begin
                n_checks++; if (uart_d_out !== 1'b0) begin n_errors++; $display("FAIL rst_mid_start: got %b expected 0", uart_d_out); end
            end
            @(negedge clk);
        end
        tx_if.tx_valid = 1'b0;
        repeat (33) @(negedge clk);
        n_checks++; if (uart_d_out !== words[0][3]) begin n_errors++; $display("FAIL rst_mid_data_bit3: got %b expected %b", uart_d_out, words[0][3]); end
        uart_reset = 1'b0;
        @(negedge clk);
        n_checks++; if (uart_d_out !== 1'b1)     begin n_errors++; $display("FAIL rst_mid_d_out: got %b expected 1", uart_d_out); end
        n_checks++; if (fifo_count !== 3'd0)     begin n_errors++; $display("FAIL rst_mid_count: got %0d expected 0", fifo_count); end
        n_checks++; if (tx_if.tx_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready: got %b expected 1", tx_if.tx_ready); end
        n_checks++; if (uart_tx_busy !== 1'b0)   begin n_errors++; $display("FAIL rst_mid_busy: got %b expected 0", uart_tx_busy); end
        uart_reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (uart_d_out !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        uart_reset     = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        baud_div       = '0;
        two_stop       = 1'b0;
        parity_odd     = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_two_stop;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_random;
        test_random;
        test_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
